sdram_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 29 ++
 rtl/sdram_arbiter_if.sv | 68 ++++++
 rtl/sdram_arb_tag_fifo.sv | 51 +++++
 rtl/sdram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared widths, grant-state encoding and read-tag layout
// for the f2h_sdram0 two-master arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W = 29;
    localparam int BURST_W = 8;
    localparam int DATA_W = 64;
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        RD0,
        RD1,
        WR1
    } gnt_e;

    typedef struct packed {
        logic               id;
        logic [BURST_W-1:0] beats;
    } tag_t;

    // A zero burstcount is treated as a single beat.
    function automatic logic [BURST_W-1:0] eff_burst(
        input logic [BURST_W-1:0] bc
    );
        return (bc == '0) ? BURST_W'(1) : bc;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Client and SDRAM-side signals of the arbiter.
// err exists only when SDRAM_ARB_ERR_EN is defined.
interface sdram_arbiter_if;
    import sdram_arb_pkg::*;

    logic [ADDR_W-1:0]  m0_address;
    logic               m0_read;
    logic               m0_waitrequest;
    logic               m0_readdatavalid;
    logic [ADDR_W-1:0]  m1_address;
    logic [BURST_W-1:0] m1_burstcount;
    logic               m1_read;
    logic               m1_write;
    logic [DATA_W-1:0]  m1_writedata;
    logic [BE_W-1:0]    m1_byteenable;
    logic               m1_waitrequest;
    logic               m1_readdatavalid;
    logic [DATA_W-1:0]  rd_data;
    logic [ADDR_W-1:0]  s_address;
    logic [BURST_W-1:0] s_burstcount;
    logic               s_read;
    logic               s_write;
    logic [DATA_W-1:0]  s_writedata;
    logic [BE_W-1:0]    s_byteenable;
    logic               s_waitrequest;
    logic [DATA_W-1:0]  s_readdata;
    logic               s_readdatavalid;
`ifdef SDRAM_ARB_ERR_EN
    logic               err;
`endif

    modport slave (
`ifdef SDRAM_ARB_ERR_EN
        output err,
`endif
        input  m0_address, m0_read,
        output m0_waitrequest, m0_readdatavalid,
        input  m1_address, m1_burstcount,
        input  m1_read, m1_write,
        input  m1_writedata, m1_byteenable,
        output m1_waitrequest, m1_readdatavalid,
        output rd_data,
        output s_address, s_burstcount,
        output s_read, s_write,
        output s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata,
        input  s_readdatavalid
    );

    modport master (
`ifdef SDRAM_ARB_ERR_EN
        input  err,
`endif
        output m0_address, m0_read,
        input  m0_waitrequest, m0_readdatavalid,
        output m1_address, m1_burstcount,
        output m1_read, m1_write,
        output m1_writedata, m1_byteenable,
        input  m1_waitrequest, m1_readdatavalid,
        input  rd_data,
        input  s_address, s_burstcount,
        input  s_read, s_write,
        input  s_writedata, s_byteenable,
        output s_waitrequest, s_readdata,
        output s_readdatavalid
    );

endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// Outstanding-read tag FIFO; the head entry counts down
// its remaining beats and pops on the last one.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  tag_t push_tag_i,
    input  logic dec_i,
    output tag_t head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    tag_t          mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          dec;
    logic          pop;

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign dec     = dec_i && !empty_o;
    assign pop     = dec && (head_o.beats <= BURST_W'(1));

    // A push at full only happens alongside a pop, so the
    // overwritten slot is the departing head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q] <= push_tag_i;
            if (dec && !pop)
                mem_q[rd_q].beats <= head_o.beats - BURST_W'(1);
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop);
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master arbiter for the HPS f2h_sdram0 port.
// Define SDRAM_ARB_ERR_EN to add the sticky err output.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter logic [BURST_W-1:0] M0_BURST      = 8'd32,
    parameter int                 MAX_PENDING   = 4,
    parameter int                 M0_MAX_CONSEC = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    sdram_arbiter_if.slave bus
);
    localparam int CW = $clog2(M0_MAX_CONSEC + 1);
    localparam logic [CW-1:0] CMAX = CW'(M0_MAX_CONSEC);

    gnt_e               state_q, state_d;
    logic [CW-1:0]      consec_q, consec_d;
    logic [BURST_W-1:0] wlen_q, wlen_d;
    logic [BURST_W-1:0] wcnt_q, wcnt_d;

    logic               push;
    tag_t               push_tag;
    tag_t               head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               ret;
    logic               m1_req;
    logic               m0_ok;
    logic [BURST_W-1:0] m1_bc;
    logic               acc;

    assign m1_req = bus.m1_read | bus.m1_write;
    assign m1_bc  = eff_burst(bus.m1_burstcount);
    assign acc    = !bus.s_waitrequest;
    assign m0_ok  = bus.m0_read && !fifo_full &&
                    !(consec_q == CMAX && m1_req);

    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        push     = 1'b0;
        push_tag = '0;
        bus.s_address      = '0;
        bus.s_burstcount   = '0;
        bus.s_read         = 1'b0;
        bus.s_write        = 1'b0;
        bus.s_writedata    = '0;
        bus.s_byteenable   = '0;
        bus.m0_waitrequest = 1'b1;
        bus.m1_waitrequest = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (!bus.m0_read) consec_d = '0;
                if (m0_ok) begin
                    state_d = RD0;
                    if (consec_q != CMAX)
                        consec_d = consec_q + CW'(1);
                end else if (bus.m1_write) begin
                    state_d  = WR1;
                    consec_d = '0;
                end else if (bus.m1_read && !fifo_full) begin
                    state_d  = RD1;
                    consec_d = '0;
                end
            end
            RD0: begin
                bus.s_address      = bus.m0_address;
                bus.s_burstcount   = M0_BURST;
                bus.s_read         = bus.m0_read;
                bus.s_byteenable   = '1;
                bus.m0_waitrequest = bus.s_waitrequest;
                if (bus.m0_read && acc) begin
                    push     = 1'b1;
                    push_tag = '{id: 1'b0, beats: M0_BURST};
                    state_d  = IDLE;
                end
            end
            RD1: begin
                bus.s_address      = bus.m1_address;
                bus.s_burstcount   = m1_bc;
                bus.s_read         = bus.m1_read;
                bus.s_byteenable   = bus.m1_byteenable;
                bus.m1_waitrequest = bus.s_waitrequest;
                if (bus.m1_read && acc) begin
                    push     = 1'b1;
                    push_tag = '{id: 1'b1, beats: m1_bc};
                    state_d  = IDLE;
                end
            end
            WR1: begin
                bus.s_address      = bus.m1_address;
                bus.s_burstcount   = m1_bc;
                bus.s_write        = bus.m1_write;
                bus.s_writedata    = bus.m1_writedata;
                bus.s_byteenable   = bus.m1_byteenable;
                bus.m1_waitrequest = bus.s_waitrequest;
                // Length is taken from the first beat only.
                if (bus.m1_write && acc) begin
                    if (wcnt_q == '0) begin
                        if (m1_bc == BURST_W'(1)) begin
                            state_d = IDLE;
                        end else begin
                            wlen_d = m1_bc;
                            wcnt_d = BURST_W'(1);
                        end
                    end else if (wcnt_q + BURST_W'(1) == wlen_q) begin
                        wcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q + BURST_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            consec_q <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
        end
    end

    sdram_arb_tag_fifo #(
        .DEPTH(MAX_PENDING)
    ) u_tags (
        .clk       (clock),
        .rst_n     (reset_n),
        .push_i    (push),
        .push_tag_i(push_tag),
        .dec_i     (bus.s_readdatavalid),
        .head_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Beats arriving with no tag outstanding are dropped.
    assign ret = bus.s_readdatavalid && !fifo_empty;
    assign bus.m0_readdatavalid = ret && !head.id;
    assign bus.m1_readdatavalid = ret && head.id;
    assign bus.rd_data = bus.s_readdata;

`ifdef SDRAM_ARB_ERR_EN
    logic err_q, err_d, m1_gnt;

    always_comb begin
        m1_gnt = (state_q == IDLE) &&
                 (state_d == RD1 || state_d == WR1);
        err_d = err_q
              | (bus.s_readdatavalid & fifo_empty)
              | (m1_gnt & (bus.m1_burstcount == '0))
              | (bus.m1_read & bus.m1_write);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM
// responder that returns queued read beats in order.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sdram_arbiter_if bus();

    sdram_arbiter #(
        .M0_BURST     (8'd32),
        .MAX_PENDING  (4),
        .M0_MAX_CONSEC(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    int cnt0 = 0;
    int cnt1 = 0;
    int beatno = 0;
    bit ret_en = 1'b0;
    bit stray = 1'b0;
    logic [ADDR_W-1:0] acc_addr[$];
    int q[$];
    logic [63:0] wlog[$];
    bit vseq[$];

    // Log accepted commands/beats just before each rising edge.
    always @(negedge clock) begin
        #4;
        if (reset_n) begin
            if (bus.s_read && !bus.s_waitrequest) begin
                acc_addr.push_back(bus.s_address);
                q.push_back(bus.s_burstcount == 0 ? 1 : int'(bus.s_burstcount));
            end
            if (bus.s_write && !bus.s_waitrequest)
                wlog.push_back(bus.s_writedata);
            if (bus.m0_readdatavalid) begin
                cnt0++;
                vseq.push_back(1'b0);
            end
            if (bus.m1_readdatavalid) begin
                cnt1++;
                vseq.push_back(1'b1);
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (ret_en && q.size() > 0) begin
            bus.s_readdatavalid = 1'b1;
            bus.s_readdata = 64'hDA7A_0000_0000_0000 | 64'(beatno);
            beatno++;
            q[0] = q[0] - 1;
            if (q[0] == 0) void'(q.pop_front());
        end else begin
            bus.s_readdatavalid = stray;
        end
    end

    task automatic wait_acc(input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < lim; t++) begin
            @(negedge clock);
            if (acc_addr.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr(input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < lim; t++) begin
            @(negedge clock);
            if (wlog.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(input int lim, output bit ok);
        ok = 1'b0;
        ret_en = 1'b1;
        for (int t = 0; t < lim; t++) begin
            @(negedge clock);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        bus.m0_read = 1'b1;
        bus.m0_address = 29'h100;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({bus.s_read, bus.s_write, bus.m0_waitrequest,
             bus.m1_waitrequest, bus.m0_readdatavalid,
             bus.m1_readdatavalid} !== 6'b001100) begin
            failures++;
            $display("FAIL reset_outs: got %b want 001100",
                {bus.s_read, bus.s_write, bus.m0_waitrequest,
                 bus.m1_waitrequest, bus.m0_readdatavalid,
                 bus.m1_readdatavalid});
        end
`ifdef SDRAM_ARB_ERR_EN
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: got %b want 0", bus.err);
        end
`endif
        @(negedge clock);
        bus.m0_read = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_m0_single();
        logic [47:0] got;
        bit seen;
        bit ok;
        cnt0 = 0;
        cnt1 = 0;
        acc_addr.delete();
        ret_en = 1'b0;
        @(negedge clock);
        bus.m0_address = 29'h100;
        bus.m0_read = 1'b1;
        #1;
        checks++;
        if (bus.s_read !== 1'b0) begin
            failures++;
            $display("FAIL m0_latency: s_read got %b want 0", bus.s_read);
        end
        @(negedge clock);
        #1;
        got = {bus.s_read, bus.s_address, bus.s_burstcount,
               bus.s_byteenable, bus.m0_waitrequest, bus.m1_waitrequest};
        checks++;
        if (got !== {1'b1, 29'h100, 8'd32, 8'hFF, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL m0_cmd: got %h want %h", got,
                {1'b1, 29'h100, 8'd32, 8'hFF, 1'b0, 1'b1});
        end
        @(negedge clock);
        bus.m0_read = 1'b0;
        checks++;
        if (acc_addr.size() != 1) begin
            failures++;
            $display("FAIL m0_accept: got %0d want 1", acc_addr.size());
        end
        ret_en = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 200 && !(seen && q.size() == 0); t++) begin
            @(negedge clock);
            #1;
            if (bus.m0_readdatavalid && !seen) begin
                seen = 1'b1;
                checks++;
                if (bus.rd_data !== bus.s_readdata) begin
                    failures++;
                    $display("FAIL rd_data: got %h want %h",
                        bus.rd_data, bus.s_readdata);
                end
            end
        end
        drain(100, ok);
        checks++;
        if (!ok || cnt0 != 32 || cnt1 != 0) begin
            failures++;
            $display("FAIL m0_beats: got %0d/%0d want 32/0", cnt0, cnt1);
        end
        // FIFO is empty now, so a stray beat must be dropped.
        #2 stray = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin
            failures++;
            $display("FAIL stray_drop: got %b want 00",
                {bus.m0_readdatavalid, bus.m1_readdatavalid});
        end
        stray = 1'b0;
    endtask

    task automatic test_priority();
        bit ord [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        logic [ADDR_W-1:0] exp;
        bit ok;
        acc_addr.delete();
        cnt0 = 0;
        cnt1 = 0;
        ret_en = 1'b1;
        @(negedge clock);
        bus.m0_address = 29'h100;
        bus.m1_address = 29'h200;
        bus.m1_burstcount = 8'd2;
        bus.m0_read = 1'b1;
        bus.m1_read = 1'b1;
        wait_acc(10, 3000, ok);
        bus.m0_read = 1'b0;
        bus.m1_read = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL prio_timeout: got %0d want 10", acc_addr.size());
        end
        for (int i = 0; i < 10 && i < acc_addr.size(); i++) begin
            exp = ord[i] ? 29'h200 : 29'h100;
            checks++;
            if (acc_addr[i] !== exp) begin
                failures++;
                $display("FAIL prio_order[%0d]: got %h want %h",
                    i, acc_addr[i], exp);
            end
        end
        drain(3000, ok);
        checks++;
        if (!ok || cnt0 != 256 || cnt1 != 4) begin
            failures++;
            $display("FAIL prio_beats: got %0d/%0d want 256/4", cnt0, cnt1);
        end
    endtask

    task automatic test_write_burst();
        logic [63:0] wd [4];
        bit ok;
        for (int i = 0; i < 4; i++) wd[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
        acc_addr.delete();
        wlog.delete();
        @(negedge clock);
        bus.m1_address = 29'h300;
        bus.m1_burstcount = 8'd4;
        bus.m1_byteenable = 8'h5A;
        bus.m1_write = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus.m1_writedata = wd[b];
            if (b == 1) begin
                bus.m0_address = 29'h100;
                bus.m0_read = 1'b1;
                bus.s_waitrequest = 1'b1;
                #1;
                checks++;
                if ({bus.s_write, bus.m1_waitrequest, bus.m0_waitrequest,
                     bus.s_byteenable} !== {3'b111, 8'h5A}) begin
                    failures++;
                    $display("FAIL wr_stall: got %h want %h",
                        {bus.s_write, bus.m1_waitrequest,
                         bus.m0_waitrequest, bus.s_byteenable},
                        {3'b111, 8'h5A});
                end
                repeat (3) @(negedge clock);
                bus.s_waitrequest = 1'b0;
            end
            for (int t = 0; t < 50 && wlog.size() <= b; t++)
                @(negedge clock);
        end
        bus.m1_write = 1'b0;
        checks++;
        if (wlog.size() != 4 || acc_addr.size() != 0) begin
            failures++;
            $display("FAIL wr_count: got %0d/%0d want 4/0",
                wlog.size(), acc_addr.size());
        end
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== wd[i]) begin
                failures++;
                $display("FAIL wr_data[%0d]: got %h want %h",
                    i, wlog[i], wd[i]);
            end
        end
        wait_acc(1, 50, ok);
        bus.m0_read = 1'b0;
        checks++;
        if (!ok || acc_addr[0] !== 29'h100) begin
            failures++;
            $display("FAIL wr_then_m0: got %0d want 1", acc_addr.size());
        end
        drain(500, ok);
    endtask

    task automatic test_interleave();
        int errs;
        bit ok;
        bit exp;
        ret_en = 1'b0;
        acc_addr.delete();
        vseq.delete();
        cnt0 = 0;
        cnt1 = 0;
        @(negedge clock);
        bus.m0_address = 29'h400;
        bus.m0_read = 1'b1;
        wait_acc(1, 50, ok);
        bus.m0_read = 1'b0;
        bus.m1_address = 29'h500;
        bus.m1_burstcount = 8'd2;
        bus.m1_read = 1'b1;
        wait_acc(2, 50, ok);
        bus.m1_read = 1'b0;
        bus.m0_read = 1'b1;
        wait_acc(3, 50, ok);
        bus.m0_read = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ilv_issue: got %0d want 3", acc_addr.size());
        end
        drain(500, ok);
        checks++;
        if (vseq.size() != 66) begin
            failures++;
            $display("FAIL ilv_len: got %0d want 66", vseq.size());
        end
        errs = 0;
        for (int i = 0; i < vseq.size(); i++) begin
            exp = (i == 32 || i == 33);
            if (vseq[i] != exp) errs++;
        end
        checks++;
        if (errs != 0 || cnt1 != 2) begin
            failures++;
            $display("FAIL ilv_route: got %0d misrouted, m1=%0d want 0, 2",
                errs, cnt1);
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        ret_en = 1'b0;
        acc_addr.delete();
        cnt0 = 0;
        @(negedge clock);
        bus.m0_address = 29'h600;
        bus.m0_read = 1'b1;
        wait_acc(4, 100, ok);
        repeat (10) @(negedge clock);
        #1;
        checks++;
        if (acc_addr.size() != 4 || bus.m0_waitrequest !== 1'b1) begin
            failures++;
            $display("FAIL full_hold: got %0d/%b want 4/1",
                acc_addr.size(), bus.m0_waitrequest);
        end
        ret_en = 1'b1;
        wait_acc(5, 200, ok);
        bus.m0_read = 1'b0;
        checks++;
        if (!ok || acc_addr.size() != 5 || cnt0 < 32) begin
            failures++;
            $display("FAIL full_release: got %0d cmds %0d beats want 5 >=32",
                acc_addr.size(), cnt0);
        end
        drain(1000, ok);
        checks++;
        if (!ok || cnt0 != 160) begin
            failures++;
            $display("FAIL full_beats: got %0d want 160", cnt0);
        end
    endtask

    task automatic test_burst0();
        bit ok;
        acc_addr.delete();
        wlog.delete();
        @(negedge clock);
        bus.m1_address = 29'h700;
        bus.m1_burstcount = 8'd0;
        bus.m1_writedata = 64'h1234;
        bus.m1_write = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if ({bus.s_write, bus.s_burstcount} !== {1'b1, 8'd1}) begin
            failures++;
            $display("FAIL bc0_cmd: got %h want %h",
                {bus.s_write, bus.s_burstcount}, {1'b1, 8'd1});
        end
        wait_wr(1, 50, ok);
        bus.m1_write = 1'b0;
        bus.m0_address = 29'h100;
        bus.m0_read = 1'b1;
        wait_acc(1, 50, ok);
        bus.m0_read = 1'b0;
        checks++;
        if (!ok || wlog.size() != 1) begin
            failures++;
            $display("FAIL bc0_single: got %0d beats %0d cmds want 1 1",
                wlog.size(), acc_addr.size());
        end
        drain(500, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        wlog.delete();
        @(negedge clock);
        bus.m1_address = 29'h800;
        bus.m1_burstcount = 8'd8;
        bus.m1_write = 1'b1;
        wait_wr(2, 50, ok);
        #1;
        checks++;
        if (!ok || bus.s_write !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: got %b want 1", bus.s_write);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.s_write, bus.s_read, bus.m0_waitrequest,
             bus.m1_waitrequest} !== 4'b0011) begin
            failures++;
            $display("FAIL rst_mid: got %b want 0011",
                {bus.s_write, bus.s_read, bus.m0_waitrequest,
                 bus.m1_waitrequest});
        end
`ifdef SDRAM_ARB_ERR_EN
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL rst_err_clr: got %b want 0", bus.err);
        end
`endif
        bus.m1_write = 1'b0;
        q.delete();
        acc_addr.delete();
        @(negedge clock);
        reset_n = 1'b1;
        #2 stray = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin
            failures++;
            $display("FAIL rst_stray: got %b want 00",
                {bus.m0_readdatavalid, bus.m1_readdatavalid});
        end
        stray = 1'b0;
        @(negedge clock);
        #1;
`ifdef SDRAM_ARB_ERR_EN
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL rst_err_set: got %b want 1", bus.err);
        end
`endif
    endtask

    initial begin
        bus.m0_address = '0;
        bus.m0_read = 1'b0;
        bus.m1_address = '0;
        bus.m1_burstcount = 8'd1;
        bus.m1_read = 1'b0;
        bus.m1_write = 1'b0;
        bus.m1_writedata = '0;
        bus.m1_byteenable = 8'hFF;
        bus.s_waitrequest = 1'b0;
        bus.s_readdata = '0;
        bus.s_readdatavalid = 1'b0;
        test_reset();
        test_m0_single();
        test_priority();
        test_write_burst();
        test_interleave();
        test_fifo_full();
        test_burst0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
